// File: rtl/maxnet_pkg.sv
// Shared types and constants for the Maxnet feeder slice.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package maxnet_pkg;

  // Default activation / result width.
  localparam int WIDTH_DEFAULT = 5;

  // Number of Maxnet inputs packed per run.
  localparam int N_IN = 4;

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2,
    OUT   = 2'd3
  } state_e;

  typedef logic [WIDTH_DEFAULT-1:0] sample_t;

endpackage

// File: rtl/maxnet_feeder_if.sv
// Bundles the feeder's upstream, Maxnet-side and downstream signals.
// Latency: n/a (wiring only).
// Backpressure: in_ready / out_ready carried as plain handshake wires.
// Ports: master = feeder view, slave = environment view (source, Maxnet, sink).
interface maxnet_feeder_if
  import maxnet_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
);
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_ready;
  logic             mx_start;
  logic [WIDTH-1:0] mx_x1;
  logic [WIDTH-1:0] mx_x2;
  logic [WIDTH-1:0] mx_x3;
  logic [WIDTH-1:0] mx_x4;
  logic             mx_done;
  logic [WIDTH-1:0] mx_result;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_ready;
  logic             out_err;

  modport master (
    input  in_valid, in_data, mx_done, mx_result, out_ready,
    output in_ready, mx_start, mx_x1, mx_x2, mx_x3, mx_x4,
           out_valid, out_data, out_err
  );

  modport slave (
    output in_valid, in_data, mx_done, mx_result, out_ready,
    input  in_ready, mx_start, mx_x1, mx_x2, mx_x3, mx_x4,
           out_valid, out_data, out_err
  );
endinterface

// File: rtl/maxnet_feeder_buf.sv
// Four-entry write-indexed register file holding one Maxnet input group.
// Latency: write visible on the outputs the cycle after we.
// Backpressure: none; writes whenever we is high.
// Ports: clk, rst (sync, active-high), we/idx/din write port, q0..q3 parallel reads.
module maxnet_feeder_buf
  import maxnet_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    we,
  input  logic [$clog2(N_IN)-1:0] idx,
  input  logic [WIDTH-1:0]        din,
  output logic [WIDTH-1:0]        q0,
  output logic [WIDTH-1:0]        q1,
  output logic [WIDTH-1:0]        q2,
  output logic [WIDTH-1:0]        q3
);

  logic [WIDTH-1:0] mem [N_IN];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N_IN; i++) mem[i] <= '0;
    end else if (we) begin
      mem[idx] <= din;
    end
  end

  assign q0 = mem[0];
  assign q1 = mem[1];
  assign q2 = mem[2];
  assign q3 = mem[3];

endmodule

// File: rtl/maxnet_feeder.sv
// Packs four serial activations, runs Maxnet once, and hands its winner downstream.
// Latency: 4th accept -> mx_start +1; armed mx_done -> out_valid +1; out_ready -> in_ready +1.
// Backpressure: in_ready only in FILL; result held in OUT until out_ready.
// Ports: clk, rst (sync, active-high), bus (maxnet_feeder_if.master).
// Optional: MAXNET_FEEDER_TIMEOUT_EN adds a wait counter that gives up after
// TIMEOUT_CYCLES WAIT cycles and reports out_data=0 with out_err=1.
module maxnet_feeder
  import maxnet_pkg::*;
#(
  parameter int WIDTH          = WIDTH_DEFAULT,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic            clk,
  input  logic            rst,
  maxnet_feeder_if.master bus
);

  localparam logic [1:0] ST_FILL  = FILL;
  localparam logic [1:0] ST_START = START;
  localparam logic [1:0] ST_WAIT  = WAIT;
  localparam logic [1:0] ST_OUT   = OUT;

  logic [1:0]       state;
  logic [1:0]       cnt;
  logic             armed;
  logic [WIDTH-1:0] res_q;
  logic             accept;
  logic             done_ok;
  logic             tmo;

  assign accept  = (state == ST_FILL) && bus.in_valid;
  // Done only counts once it has been seen low in this run, so a level-held
  // done from the previous run cannot complete the new one.
  assign done_ok = (state == ST_WAIT) && armed && bus.mx_done;

  maxnet_feeder_buf #(.WIDTH(WIDTH)) u_buf (
    .clk (clk),
    .rst (rst),
    .we  (accept),
    .idx (cnt),
    .din (bus.in_data),
    .q0  (bus.mx_x1),
    .q1  (bus.mx_x2),
    .q2  (bus.mx_x3),
    .q3  (bus.mx_x4)
  );

`ifdef MAXNET_FEEDER_TIMEOUT_EN
  localparam int TW = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;

  logic [TW-1:0] wcnt;
  logic          err_q;

  // wcnt holds the number of WAIT cycles already spent, so this fires in the
  // TIMEOUT_CYCLES-th WAIT cycle; a real done in that same cycle still wins.
  assign tmo = (state == ST_WAIT) && !done_ok && (wcnt == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      wcnt  <= '0;
      err_q <= 1'b0;
    end else begin
      if (state == ST_START)     wcnt <= '0;
      else if (state == ST_WAIT) wcnt <= wcnt + 1'b1;

      if (tmo)                                err_q <= 1'b1;
      else if (state == ST_OUT && bus.out_ready) err_q <= 1'b0;
    end
  end

  assign bus.out_err = err_q;
`else
  localparam int tmo_unused = TIMEOUT_CYCLES;
  assign tmo         = 1'b0;
  assign bus.out_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_FILL;
      cnt   <= 2'd0;
      armed <= 1'b0;
      res_q <= '0;
    end else begin
      case (state)
        ST_FILL: begin
          if (accept) begin
            cnt <= cnt + 2'd1;
            if (cnt == 2'd3) state <= ST_START;
          end
        end
        ST_START: begin
          armed <= 1'b0;
          state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (!bus.mx_done) armed <= 1'b1;
          if (done_ok) begin
            res_q <= bus.mx_result;
            state <= ST_OUT;
          end else if (tmo) begin
            res_q <= '0;
            state <= ST_OUT;
          end
        end
        default: begin
          if (bus.out_ready) begin
            cnt   <= 2'd0;
            state <= ST_FILL;
          end
        end
      endcase
    end
  end

  assign bus.in_ready  = (state == ST_FILL);
  assign bus.mx_start  = (state == ST_START);
  assign bus.out_valid = (state == ST_OUT);
  assign bus.out_data  = res_q;

endmodule

// File: tb/tb_maxnet_feeder.sv
// Directed bench for maxnet_feeder: table of full runs plus hand-written
// stale-done, reset and (with MAXNET_FEEDER_TIMEOUT_EN) timeout sequences.
// Inputs change 1ns after the rising edge; outputs are read at that point.
module tb_maxnet_feeder;
  import maxnet_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  maxnet_feeder_if #(.WIDTH(5)) ifc ();

  maxnet_feeder #(.WIDTH(5), .TIMEOUT_CYCLES(20)) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc)
  );

  int n_cmp = 0;
  int n_err = 0;
  int starts = 0;

  always @(negedge clk) if (ifc.mx_start === 1'b1) starts++;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [0:3][4:0] s;
    bit              gapped;
    int              dly;
    int              hold;
    logic [4:0]      res;
    logic [0:3][4:0] ex;
    logic [4:0]      eo;
  } vec_t;

  vec_t v[4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offer one sample and wait (bounded) until it is taken.
  task automatic send(input logic [4:0] d);
    int k;
    k = 0;
    ifc.in_valid = 1'b1;
    ifc.in_data  = d;
    while (ifc.in_ready !== 1'b1 && k < 50) begin
      step();
      k++;
    end
    if (ifc.in_ready !== 1'b1) begin
      n_cmp++;
      n_err++;
      $display("FAIL send_wait: in_ready never rose, got %b expected 1", ifc.in_ready);
    end
    step();
    ifc.in_valid = 1'b0;
  endtask

  task automatic fill4(input logic [0:3][4:0] s, input bit gapped);
    for (int i = 0; i < 4; i++) begin
      if (gapped && i > 0) begin
        ifc.in_valid = 1'b0;
        ifc.in_data  = 5'h1f;
        step();
      end
      send(s[i]);
    end
  endtask

  task automatic chk_x(input string name, input logic [0:3][4:0] e);
    chk({name, "_x1"}, ifc.mx_x1, e[0]);
    chk({name, "_x2"}, ifc.mx_x2, e[1]);
    chk({name, "_x3"}, ifc.mx_x3, e[2]);
    chk({name, "_x4"}, ifc.mx_x4, e[3]);
  endtask

  task automatic drain(input string name);
    ifc.out_ready = 1'b1;
    step();
    ifc.out_ready = 1'b0;
    chk({name, "_in_ready_after"}, ifc.in_ready, 1);
    chk({name, "_out_valid_after"}, ifc.out_valid, 0);
  endtask

  task automatic chk_reset(input string name);
    chk({name, "_in_ready"}, ifc.in_ready, 1);
    chk({name, "_start"}, ifc.mx_start, 0);
    chk({name, "_out_valid"}, ifc.out_valid, 0);
    chk({name, "_out_data"}, ifc.out_data, 0);
    chk({name, "_out_err"}, ifc.out_err, 0);
    chk_x(name, {5'd0, 5'd0, 5'd0, 5'd0});
  endtask

  initial begin
    int s0;
    int n;

    v[0] = '{s: {5'd3, 5'd17, 5'd9, 5'd30}, gapped: 1'b0, dly: 6, hold: 10,
             res: 5'd30, ex: {5'd3, 5'd17, 5'd9, 5'd30}, eo: 5'd30};
    v[1] = '{s: {5'd5, 5'd5, 5'd5, 5'd1}, gapped: 1'b1, dly: 3, hold: 0,
             res: 5'd5, ex: {5'd5, 5'd5, 5'd5, 5'd1}, eo: 5'd5};
    v[2] = '{s: {5'd31, 5'd0, 5'd16, 5'd1}, gapped: 1'b0, dly: 2, hold: 2,
             res: 5'd16, ex: {5'd31, 5'd0, 5'd16, 5'd1}, eo: 5'd16};
    v[3] = '{s: {5'd8, 5'd21, 5'd21, 5'd2}, gapped: 1'b1, dly: 4, hold: 1,
             res: 5'd21, ex: {5'd8, 5'd21, 5'd21, 5'd2}, eo: 5'd21};

    rst           = 1'b1;
    ifc.in_valid  = 1'b0;
    ifc.in_data   = 5'd0;
    ifc.mx_done   = 1'b0;
    ifc.mx_result = 5'd0;
    ifc.out_ready = 1'b0;
    step();
    step();
    rst = 1'b0;
    chk_reset("reset");

    // Table-driven full runs.
    for (int i = 0; i < 4; i++) begin
      s0 = starts;
      fill4(v[i].s, v[i].gapped);
      chk($sformatf("v%0d_start", i), ifc.mx_start, 1);
      chk_x($sformatf("v%0d", i), v[i].ex);
      // Samples offered outside FILL must be ignored.
      ifc.in_valid = 1'b1;
      ifc.in_data  = 5'd7;
      step();
      chk($sformatf("v%0d_start_one_cycle", i), ifc.mx_start, 0);
      chk($sformatf("v%0d_in_ready_wait", i), ifc.in_ready, 0);
      for (int k = 1; k < v[i].dly; k++) step();
      ifc.in_valid  = 1'b0;
      ifc.mx_done   = 1'b1;
      ifc.mx_result = v[i].res;
      chk($sformatf("v%0d_no_early_valid", i), ifc.out_valid, 0);
      step();
      ifc.mx_done = 1'b0;
      chk($sformatf("v%0d_out_valid", i), ifc.out_valid, 1);
      chk($sformatf("v%0d_out_data", i), ifc.out_data, v[i].eo);
      chk($sformatf("v%0d_out_err", i), ifc.out_err, 0);
      chk_x($sformatf("v%0d_stable", i), v[i].ex);
      for (int h = 0; h < v[i].hold; h++) begin
        step();
        chk($sformatf("v%0d_hold%0d_valid", i, h), ifc.out_valid, 1);
        chk($sformatf("v%0d_hold%0d_data", i, h), ifc.out_data, v[i].eo);
        chk($sformatf("v%0d_hold%0d_in_ready", i, h), ifc.in_ready, 0);
      end
      drain($sformatf("v%0d", i));
      chk($sformatf("v%0d_start_count", i), starts - s0, 1);
    end

    // Done left high from before START must not complete the run.
    ifc.mx_done   = 1'b1;
    ifc.mx_result = 5'd25;
    fill4({5'd1, 5'd2, 5'd3, 5'd4}, 1'b0);
    chk("stale_start", ifc.mx_start, 1);
    step();
    chk("stale_wait1_valid", ifc.out_valid, 0);
    step();
    chk("stale_wait2_valid", ifc.out_valid, 0);
    ifc.mx_done = 1'b0;
    step();
    chk("stale_armed_valid", ifc.out_valid, 0);
    ifc.mx_done   = 1'b1;
    ifc.mx_result = 5'd12;
    step();
    ifc.mx_done = 1'b0;
    chk("stale_out_valid", ifc.out_valid, 1);
    chk("stale_out_data", ifc.out_data, 12);
    drain("stale");

    // Reset during WAIT, then during a partial fill.
    fill4({5'd9, 5'd9, 5'd9, 5'd9}, 1'b0);
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk_reset("rst_wait");
    send(5'd1);
    send(5'd3);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk_reset("rst_fill");
    fill4({5'd2, 5'd4, 5'd6, 5'd8}, 1'b0);
    chk("rst_refill_start", ifc.mx_start, 1);
    chk_x("rst_refill", {5'd2, 5'd4, 5'd6, 5'd8});
    step();
    step();
    ifc.mx_done   = 1'b1;
    ifc.mx_result = 5'd8;
    step();
    ifc.mx_done = 1'b0;
    chk("rst_refill_out_data", ifc.out_data, 8);
    drain("rst_refill");

`ifdef MAXNET_FEEDER_TIMEOUT_EN
    fill4({5'd7, 5'd7, 5'd7, 5'd7}, 1'b0);
    n = 0;
    while (ifc.out_valid !== 1'b1 && n < 100) begin
      step();
      n++;
    end
    chk("tmo_latency", n, 21);
    chk("tmo_out_data", ifc.out_data, 0);
    chk("tmo_out_err", ifc.out_err, 1);
    drain("tmo");
    chk("tmo_err_cleared", ifc.out_err, 0);
`else
    n = 0;
    chk("no_tmo_err", ifc.out_err, n);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
